// File: rtl/irq_priority_resolver.sv
// irq_priority_resolver: 8259-style priority resolver and in-service register.
// Picks the highest-priority unmasked request under the current rotation,
// raises INT, runs the two-strobe INTA handshake that latches the served
// level into the ISR and issues the vector, and applies EOI / rotation
// commands.
//
// Handshake: ack1, ack2 and eoi_valid are single-cycle strobes that are
// sampled on the rising edge of clk; there is no backpressure. irr_clear and
// vector_valid are single-cycle pulses. ack1 is honoured only in IDLE and
// ack2 only in WAIT_ACK2; a strobe in any other state is ignored.
module irq_priority_resolver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [4:0] vector_base,
  input  logic       ack1,
  input  logic       ack2,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       rotate_on_eoi,
  input  logic       auto_eoi,
  input  logic       auto_rotate,
  input  logic       special_mask,
  output logic       int_req,
  output logic [7:0] isr,
  output logic [2:0] highest_isr_level,
  output logic       isr_valid,
  output logic [7:0] irr_clear,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic [2:0] lowest_priority
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_ACK2 = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] lp_q, lp_d;
  logic       int_req_q, int_req_d;
  logic [7:0] irr_clear_q, irr_clear_d;
  logic [7:0] vector_q, vector_d;
  logic       vector_valid_q, vector_valid_d;
  logic [2:0] level_q, level_d;
  logic       spurious_q, spurious_d;

  logic [7:0] cand;
  logic       has_cand;
  logic [2:0] winner;
  logic [2:0] hi_level;
  logic       isr_any;
  logic       eligible;

  // Highest-priority set bit of v when lp is the lowest-priority level.
  // Scanning from the lowest rank upward lets the last hit be the winner.
  function automatic logic [2:0] pick(input logic [7:0] v, input logic [2:0] lp);
    logic [2:0] res;
    logic [2:0] idx;
    res = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      idx = 3'(lp + 3'(k));
      if (v[idx]) res = idx;
    end
    return res;
  endfunction

  // Rank 0 is the highest priority level under the current rotation.
  function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] lp);
    return 3'(lvl - lp - 3'd1);
  endfunction

  // Candidate selection, ISR priority and eligibility from registered state.
  always_comb begin
    cand     = irr & ~imr;
    has_cand = |cand;
    winner   = pick(cand, lp_q);
    isr_any  = |isr_q;
    hi_level = isr_any ? pick(isr_q, lp_q) : 3'd0;
    eligible = 1'b0;
    if (has_cand) begin
      if (special_mask) begin
        eligible = ~isr_q[winner];
      end else begin
        eligible = ~isr_any || (rank(winner, lp_q) < rank(hi_level, lp_q));
      end
    end
  end

  // Next-state: INTA handshake, EOI handling and rotation pointer.
  always_comb begin
    state_d        = state_q;
    isr_d          = isr_q;
    lp_d           = lp_q;
    int_req_d      = 1'b0;
    irr_clear_d    = 8'h00;
    vector_d       = vector_q;
    vector_valid_d = 1'b0;
    level_d        = level_q;
    spurious_d     = spurious_q;

    // AEOI at the end of the handshake; an explicit EOI below may override
    // the rotation it requests.
    if (state_q == WAIT_ACK2 && ack2) begin
      state_d        = IDLE;
      vector_d       = {vector_base, level_q};
      vector_valid_d = 1'b1;
      if (auto_eoi && !spurious_q) begin
        isr_d[level_q] = 1'b0;
        if (auto_rotate) lp_d = level_q;
      end
    end

    // EOI acts on the pre-edge ISR.
    if (eoi_valid) begin
      if (eoi_specific) begin
        isr_d[eoi_level] = 1'b0;
        if (rotate_on_eoi) lp_d = eoi_level;
      end else if (isr_any) begin
        isr_d[hi_level] = 1'b0;
        if (rotate_on_eoi) lp_d = hi_level;
      end
    end

    // First INTA: latch the winner last so a same-cycle EOI cannot undo it.
    if (state_q == IDLE && ack1) begin
      state_d = WAIT_ACK2;
      if (has_cand) begin
        level_d             = winner;
        spurious_d          = 1'b0;
        isr_d[winner]       = 1'b1;
        irr_clear_d[winner] = 1'b1;
      end else begin
        level_d    = 3'd7;
        spurious_d = 1'b1;
      end
    end

    // INT is held low from the ack1 edge through the ack2 edge.
    if (state_q == IDLE && !ack1) begin
      int_req_d = eligible;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      isr_q          <= 8'h00;
      lp_q           <= 3'd7;
      int_req_q      <= 1'b0;
      irr_clear_q    <= 8'h00;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
      level_q        <= 3'd0;
      spurious_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      isr_q          <= isr_d;
      lp_q           <= lp_d;
      int_req_q      <= int_req_d;
      irr_clear_q    <= irr_clear_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
      level_q        <= level_d;
      spurious_q     <= spurious_d;
    end
  end

  assign int_req           = int_req_q;
  assign isr               = isr_q;
  assign highest_isr_level = hi_level;
  assign isr_valid         = isr_any;
  assign irr_clear         = irr_clear_q;
  assign vector            = vector_q;
  assign vector_valid      = vector_valid_q;
  assign lowest_priority   = lp_q;

endmodule

// File: tb/tb_irq_priority_resolver.sv
// Directed bench for irq_priority_resolver with hand-computed expectations.
module tb_irq_priority_resolver;

  logic       clk;
  logic       rst_n;
  logic [7:0] irr;
  logic [7:0] imr;
  logic [4:0] vector_base;
  logic       ack1;
  logic       ack2;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       rotate_on_eoi;
  logic       auto_eoi;
  logic       auto_rotate;
  logic       special_mask;
  logic       int_req;
  logic [7:0] isr;
  logic [2:0] highest_isr_level;
  logic       isr_valid;
  logic [7:0] irr_clear;
  logic [7:0] vector;
  logic       vector_valid;
  logic [2:0] lowest_priority;

  int total;
  int bad;

  irq_priority_resolver dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .irr               (irr),
    .imr               (imr),
    .vector_base       (vector_base),
    .ack1              (ack1),
    .ack2              (ack2),
    .eoi_valid         (eoi_valid),
    .eoi_specific      (eoi_specific),
    .eoi_level         (eoi_level),
    .rotate_on_eoi     (rotate_on_eoi),
    .auto_eoi          (auto_eoi),
    .auto_rotate       (auto_rotate),
    .special_mask      (special_mask),
    .int_req           (int_req),
    .isr               (isr),
    .highest_isr_level (highest_isr_level),
    .isr_valid         (isr_valid),
    .irr_clear         (irr_clear),
    .vector            (vector),
    .vector_valid      (vector_valid),
    .lowest_priority   (lowest_priority)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ack1();
    ack1 = 1'b1;
    step();
    ack1 = 1'b0;
  endtask

  task automatic pulse_ack2();
    ack2 = 1'b1;
    step();
    ack2 = 1'b0;
  endtask

  task automatic pulse_eoi(input logic spec, input logic [2:0] lvl, input logic rot);
    eoi_valid     = 1'b1;
    eoi_specific  = spec;
    eoi_level     = lvl;
    rotate_on_eoi = rot;
    step();
    eoi_valid     = 1'b0;
    eoi_specific  = 1'b0;
    eoi_level     = 3'd0;
    rotate_on_eoi = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    irr = 8'h00; imr = 8'h00; vector_base = 5'h11;
    ack1 = 0; ack2 = 0; eoi_valid = 0; eoi_specific = 0; eoi_level = 3'd0;
    rotate_on_eoi = 0; auto_eoi = 0; auto_rotate = 0; special_mask = 0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset state
    check("rst_isr", isr, 8'h00);
    check("rst_lp", {5'd0, lowest_priority}, 8'h07);
    check("rst_int", {7'd0, int_req}, 8'h00);
    check("rst_vec", vector, 8'h00);
    check("rst_vv", {7'd0, vector_valid}, 8'h00);
    check("rst_isr_valid", {7'd0, isr_valid}, 8'h00);

    // Basic serve of IR2 out of {IR2, IR5}
    irr = 8'h24;
    step();
    check("t1_int", {7'd0, int_req}, 8'h01);
    pulse_ack1();
    check("t1_isr", isr, 8'h04);
    check("t1_irr_clear", irr_clear, 8'h04);
    check("t1_int_low", {7'd0, int_req}, 8'h00);
    check("t1_hi", {5'd0, highest_isr_level}, 8'h02);
    irr = 8'h20;
    step();
    check("t1_irr_clear_end", irr_clear, 8'h00);
    pulse_ack2();
    check("t1_vec", vector, 8'h8a);
    check("t1_vv", {7'd0, vector_valid}, 8'h01);
    step();
    check("t1_vv_end", {7'd0, vector_valid}, 8'h00);
    check("t1_int_blocked", {7'd0, int_req}, 8'h00);

    // Nesting: IR1 beats in-service IR2, IR3 does not; non-specific EOI
    irr = 8'h02;
    step();
    check("t2_int_ir1", {7'd0, int_req}, 8'h01);
    irr = 8'h08;
    step();
    check("t2_int_ir3", {7'd0, int_req}, 8'h00);
    pulse_eoi(1'b0, 3'd0, 1'b0);
    check("t2_isr_eoi", isr, 8'h00);
    step();
    check("t2_int_after_eoi", {7'd0, int_req}, 8'h01);

    // AEOI with auto rotate serving IR3
    auto_eoi = 1'b1; auto_rotate = 1'b1;
    pulse_ack1();
    check("t3_isr", isr, 8'h08);
    irr = 8'h00;
    pulse_ack2();
    check("t3_vec", vector, 8'h8b);
    check("t3_isr_aeoi", isr, 8'h00);
    check("t3_lp", {5'd0, lowest_priority}, 8'h03);
    // Order 4..7,0..3: IR0 beats IR3
    irr = 8'h09;
    step();
    check("t3_int", {7'd0, int_req}, 8'h01);
    pulse_ack1();
    check("t3_irr_clear_ir0", irr_clear, 8'h01);
    irr = 8'h08;
    pulse_ack2();
    check("t3_vec_ir0", vector, 8'h88);
    check("t3_lp_ir0", {5'd0, lowest_priority}, 8'h00);
    auto_eoi = 1'b0; auto_rotate = 1'b0;

    // Serve IR1 (order 1..7,0), then a spurious ack with irr=0
    irr = 8'h02;
    step();
    pulse_ack1();
    irr = 8'h00;
    pulse_ack2();
    check("t4_isr_ir1", isr, 8'h02);
    check("t4_vec_ir1", vector, 8'h89);
    pulse_ack1();
    check("t4_spur_isr", isr, 8'h02);
    check("t4_spur_clear", irr_clear, 8'h00);
    pulse_ack2();
    check("t4_spur_vec", vector, 8'h8f);
    check("t4_spur_vv", {7'd0, vector_valid}, 8'h01);

    // Specific EOI clears IR1; rotating EOI on an already clear bit
    pulse_eoi(1'b1, 3'd1, 1'b0);
    check("t5_isr_eoi1", isr, 8'h00);
    pulse_eoi(1'b1, 3'd7, 1'b1);
    check("t5_lp7", {5'd0, lowest_priority}, 8'h07);
    check("t5_isr_same", isr, 8'h00);

    // Special mask: IR0 in service and masked, IR7 pending
    irr = 8'h01;
    step();
    pulse_ack1();
    irr = 8'h00;
    pulse_ack2();
    check("t6_isr_ir0", isr, 8'h01);
    imr = 8'h01; irr = 8'h80;
    step(); step();
    check("t6_int_normal", {7'd0, int_req}, 8'h00);
    special_mask = 1'b1;
    step();
    check("t6_int_smm", {7'd0, int_req}, 8'h01);
    pulse_eoi(1'b1, 3'd5, 1'b1);
    check("t6_lp5", {5'd0, lowest_priority}, 8'h05);
    check("t6_isr_kept", isr, 8'h01);
    special_mask = 1'b0; imr = 8'h00; irr = 8'h00;
    pulse_eoi(1'b1, 3'd0, 1'b0);
    check("t6_isr_clear", isr, 8'h00);

    // EOI and ack1 on the same bit: set wins (order 6,7,0..5)
    irr = 8'h04;
    step();
    pulse_ack1();
    irr = 8'h00;
    pulse_ack2();
    check("t7_isr_ir2", isr, 8'h04);
    irr = 8'h04;
    ack1 = 1'b1;
    pulse_eoi(1'b1, 3'd2, 1'b0);
    ack1 = 1'b0;
    check("t7_set_wins", isr, 8'h04);
    check("t7_irr_clear", irr_clear, 8'h04);
    irr = 8'h00;
    pulse_ack2();
    check("t7_vec", vector, 8'h8a);

    // Reset while waiting for ack2
    irr = 8'h01;
    step();
    check("t8_int", {7'd0, int_req}, 8'h01);
    pulse_ack1();
    check("t8_isr", isr, 8'h05);
    rst_n = 1'b0;
    #1;
    check("t8_rst_isr", isr, 8'h00);
    check("t8_rst_lp", {5'd0, lowest_priority}, 8'h07);
    check("t8_rst_int", {7'd0, int_req}, 8'h00);
    check("t8_rst_clear", irr_clear, 8'h00);
    check("t8_rst_vec", vector, 8'h00);
    step();
    rst_n = 1'b1;
    irr = 8'h00;
    pulse_ack2();
    check("t8_no_vv", {7'd0, vector_valid}, 8'h00);
    check("t8_no_vec", vector, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_priority_resolver.md
# irq_priority_resolver

Priority resolver and in-service register (ISR) stage of the 8259 PIC, sitting directly downstream of the control logic. Takes the latched IRR, the OCW1 mask, and the INTA/EOI/rotate commands decoded by the control logic. Drives INT to the CPU, owns the ISR and rotation pointer, and returns the highest in-service level (for non-specific EOI) and the interrupt vector byte for the second INTA cycle.

## Interface
Parameters: none (fixed 8 levels).
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- irr  in  8  pending requests from the IRR latch (bit n = IRn)
- imr  in  8  mask (OCW1); 1 = masked
- vector_base  in  5  ICW2[7:3]
- ack1  in  1  one-cycle strobe, first INTA
- ack2  in  1  one-cycle strobe, second INTA
- eoi_valid  in  1  one-cycle strobe, OCW2 EOI command
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific
- eoi_level  in  3  level for specific EOI
- rotate_on_eoi  in  1  rotate priority with this EOI
- auto_eoi  in  1  ICW4 AEOI
- auto_rotate  in  1  rotate-in-AEOI mode
- special_mask  in  1  special mask mode (OCW3)
- int_req  out  1  INT to CPU, registered
- isr  out  8  in-service register
- highest_isr_level  out  3  highest-priority set ISR bit, current rotation; 0 when ISR empty
- isr_valid  out  1  |isr
- irr_clear  out  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit
- vector  out  8  {vector_base, level}, registered
- vector_valid  out  1  one-cycle pulse, vector is valid
- lowest_priority  out  3  rotation pointer, lowest-priority level

## Operation
- Priority order: (lowest_priority+1) mod 8 highest, wrapping to lowest_priority lowest.
- Candidate set = irr & ~imr; winner = highest-priority candidate.
- Blocking, normal mode: winner eligible only if strictly higher priority than highest_isr_level, or ISR empty.
- Blocking, special_mask: winner eligible if its own ISR bit is clear; other ISR bits ignored.
- FSM states: IDLE, WAIT_ACK2.
  - IDLE + ack1 → WAIT_ACK2.
    - Latch level = current winner; set isr[level]; pulse irr_clear[level].
    - No candidate → spurious: latch level 7, no ISR set, no irr_clear.
  - WAIT_ACK2 + ack2 → IDLE.
    - vector = {vector_base, level}; pulse vector_valid.
    - auto_eoi: clear isr[level] (not spurious). auto_rotate as well: lowest_priority = level.
- ack1 in WAIT_ACK2 ignored. ack2 in IDLE ignored.
- Non-specific EOI: clears isr[highest_isr_level]; rotate_on_eoi sets lowest_priority to that level. ISR empty → no effect.
- Specific EOI: clears isr[eoi_level]; rotate_on_eoi sets lowest_priority = eoi_level, even if the bit was already clear.
- Simultaneous EOI and ack1: EOI evaluated on pre-edge ISR. If both target the same bit, set wins.
- Simultaneous EOI rotate and AEOI rotate: EOI rotate wins.

## Timing
- Reset values: isr=0, lowest_priority=7 (IR0 highest), int_req=0, irr_clear=0, vector=0, vector_valid=0, FSM=IDLE.
- int_req: registered, asserts one cycle after an eligible winner appears. Forced 0 from the cycle after ack1 until the cycle after ack2. Re-evaluated from the cycle after ack2.
- isr, irr_clear: update on the ack1 edge.
- vector, vector_valid: valid in the cycle following the ack2 edge.
- highest_isr_level, isr_valid: combinational from registered isr and lowest_priority.
- rst_n low mid-sequence: immediate return to reset values; no pending vector issued.

## Test plan
- Reset → isr=00, lowest_priority=7, int_req=0; irr=0x24, imr=0 → int_req=1 next cycle; ack1 → isr=0x04, irr_clear=0x04; ack2 with vector_base=0x11 → vector=0x8A, vector_valid for 1 cycle.
- isr=0x04, irr=0x02 → int_req=1 (IR1 beats IR2); irr=0x08 → int_req=0; non-specific EOI → isr=0x00, int_req=1.
- auto_eoi=1, auto_rotate=1, serve IR3 → after ack2 isr=0, lowest_priority=3; irr=0x09 → IR4-order winner is IR0? No: order 4..7,0..3 → IR0 (bit0) served over IR3, vector level 0.
- ack1 with irr=0 → vector level 7, isr unchanged, irr_clear=0.
- special_mask=1, isr=0x01, imr=0x01, irr=0x80 → int_req=1. Specific EOI level 5 with rotate_on_eoi → lowest_priority=5.
- eoi_valid and ack1 same cycle on IR2 with isr=0x04 → isr stays 0x04. rst_n low in WAIT_ACK2 → all outputs at reset values, no vector_valid.
